// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants, colour struct and test-bar lookup
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Eight 80-pixel bars: white, yellow, cyan, green, magenta, red, blue, black
    function automatic rgb_t bar_colour(input logic [9:0] x);
        rgb_t c;
        if (x < 10'd80)       c = '{8'hFF, 8'hFF, 8'hFF};
        else if (x < 10'd160) c = '{8'hFF, 8'hFF, 8'h00};
        else if (x < 10'd240) c = '{8'h00, 8'hFF, 8'hFF};
        else if (x < 10'd320) c = '{8'h00, 8'hFF, 8'h00};
        else if (x < 10'd400) c = '{8'hFF, 8'h00, 8'hFF};
        else if (x < 10'd480) c = '{8'hFF, 8'h00, 8'h00};
        else if (x < 10'd560) c = '{8'h00, 8'h00, 8'hFF};
        else                  c = '{8'h00, 8'h00, 8'h00};
        return c;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// rtl/vga_counter.sv - mod-N counter with enable and same-cycle wrap pulse
module vga_counter #(
    parameter int unsigned N = 800,
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = i_en && (r_count == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : r_count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing, sync/blank decode and registered colour output
// Optional colour bars via VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned P_V_VISIBLE = V_VISIBLE,
    parameter int unsigned P_V_FRONT   = V_FRONT,
    parameter int unsigned P_V_SYNC    = V_SYNC,
    parameter int unsigned P_V_BACK    = V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       test_pattern,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_clk,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       vblank,
    output logic       frame_start
);

    localparam int unsigned L_V_TOTAL    = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;
    localparam int unsigned L_V_SYNC_BEG = P_V_VISIBLE + P_V_FRONT;
    localparam int unsigned L_V_SYNC_END = L_V_SYNC_BEG + P_V_SYNC - 1;

    logic       r_div;
    logic       r_hsync_n;
    logic       r_vsync_n;
    logic       r_blank_n;
    logic       r_frame_start;
    rgb_t       r_rgb;

    logic       w_pe;
    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_act;
    rgb_t       w_src;
    rgb_t       w_pix;

    // Counters and outputs move on the edge where div falls, i.e. vga_clk falling
    assign w_pe = r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_div <= 1'b0;
        else        r_div <= !r_div;
    end

    vga_counter #(.N(H_TOTAL), .W(10)) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_pe),
        .o_count (w_x),
        .o_wrap  (w_h_wrap)
    );

    vga_counter #(.N(L_V_TOTAL), .W(10)) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_h_wrap),
        .o_count (w_y),
        .o_wrap  (w_v_wrap)
    );

    assign w_hs_raw = !((w_x >= 10'(H_SYNC_START)) && (w_x <= 10'(H_SYNC_END)));
    assign w_vs_raw = !((w_y >= 10'(L_V_SYNC_BEG)) && (w_y <= 10'(L_V_SYNC_END)));
    assign w_act    = (w_x < 10'(H_VISIBLE)) && (w_y < 10'(P_V_VISIBLE));

`ifdef VGA_TIMING_TEST_PATTERN_EN
    assign w_src = test_pattern ? bar_colour(w_x) : rgb_t'({r_in, g_in, b_in});
`else
    logic w_unused_test_pattern;
    assign w_unused_test_pattern = test_pattern;
    assign w_src = rgb_t'({r_in, g_in, b_in});
`endif

    assign w_pix = w_act ? w_src : rgb_t'('0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_wrap;
            if (w_pe) begin
                r_hsync_n <= w_hs_raw;
                r_vsync_n <= w_vs_raw;
                r_blank_n <= w_act;
                r_rgb     <= w_pix;
            end
        end
    end

    assign x           = w_x;
    assign y           = w_y;
    assign vga_clk     = r_div;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign blank_n     = r_blank_n;
    assign r           = r_rgb.r;
    assign g           = r_rgb.g;
    assign b           = r_rgb.b;
    assign vblank      = (w_y >= 10'(P_V_VISIBLE));
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed and table-driven checks for vga_timing_gen (shortened vertical timing)
module tb_vga_timing_gen;

    localparam int VT    = 8;
    localparam int FRAME = 800 * 2 * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] r_in = 8'h00;
    logic [7:0] g_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       test_pattern = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       vga_clk;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       vblank;
    logic       frame_start;

    vga_timing_gen #(
        .P_V_VISIBLE (4),
        .P_V_FRONT   (1),
        .P_V_SYNC    (2),
        .P_V_BACK    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .test_pattern (test_pattern),
        .x            (x),
        .y            (y),
        .vga_clk      (vga_clk),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .blank_n      (blank_n),
        .r            (r),
        .g            (g),
        .b            (b),
        .vblank       (vblank),
        .frame_start  (frame_start)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] r;
        logic       vb;
        logic       fs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    function automatic vec_t mk(int c, int vx, int vy, bit hs, bit vs, bit bl, int vr, bit vb, bit fs);
        vec_t v;
        v.cyc = c; v.x = 10'(vx); v.y = 10'(vy); v.hs = hs; v.vs = vs;
        v.bl = bl; v.r = 8'(vr); v.vb = vb; v.fs = fs;
        return v;
    endfunction

    int         n, p, px, py;
    int         ex_x, ex_y;
    logic       e_hs, e_vs, e_bl, e_vb, e_fs;
    logic [7:0] e_r, e_g, e_b;
    int         err_xy, err_clk, err_sync, err_blank, err_rgb, err_vb, err_fs;
    int         hs_low, vs_low, fs_cnt, fs_first;
    logic [7:0] e_pat_r, e_pat_g, e_pat_b;

    initial begin
        // cyc, x, y, hsync_n, vsync_n, blank_n, r, vblank, frame_start
        vecs.push_back(mk(0,     0,   0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1,     0,   0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(2,     1,   0, 1, 1, 1, 8'hAB, 0, 0));
        vecs.push_back(mk(1280,  640, 0, 1, 1, 1, 8'hAB, 0, 0));
        vecs.push_back(mk(1282,  641, 0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1312,  656, 0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1314,  657, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1504,  752, 0, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1506,  753, 0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1600,  0,   1, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1602,  1,   1, 1, 1, 1, 8'hAB, 0, 0));
        vecs.push_back(mk(6400,  0,   4, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(6402,  1,   4, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(8000,  0,   5, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(8002,  1,   5, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(11200, 0,   7, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk(11202, 1,   7, 1, 1, 0, 8'h00, 1, 0));
        vecs.push_back(mk(12800, 0,   0, 1, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(12801, 0,   0, 1, 1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(12802, 1,   0, 1, 1, 1, 8'hAB, 0, 0));

        r_in = 8'hAB; g_in = 8'hCD; b_in = 8'hEF; test_pattern = 1'b0;
        do_reset();
        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) tick();
            check("tbl_x",     x,           vecs[i].x);
            check("tbl_y",     y,           vecs[i].y);
            check("tbl_vgaclk", vga_clk,    cyc % 2);
            check("tbl_hsync", hsync_n,     vecs[i].hs);
            check("tbl_vsync", vsync_n,     vecs[i].vs);
            check("tbl_blank", blank_n,     vecs[i].bl);
            check("tbl_r",     r,           vecs[i].r);
            check("tbl_g",     g,           vecs[i].bl ? 8'hCD : 8'h00);
            check("tbl_b",     b,           vecs[i].bl ? 8'hEF : 8'h00);
            check("tbl_vblank", vblank,     vecs[i].vb);
            check("tbl_fstart", frame_start, vecs[i].fs);
        end

        // Colour bars at pixel 85 (yellow) and 600 (black), or passthrough without the macro
        r_in = 8'h11; g_in = 8'h22; b_in = 8'h33; test_pattern = 1'b1;
        do_reset();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        e_pat_r = 8'hFF; e_pat_g = 8'hFF; e_pat_b = 8'h00;
`else
        e_pat_r = 8'h11; e_pat_g = 8'h22; e_pat_b = 8'h33;
`endif
        while (cyc < 172) tick();
        check("pat85_r", r, e_pat_r);
        check("pat85_g", g, e_pat_g);
        check("pat85_b", b, e_pat_b);
`ifdef VGA_TIMING_TEST_PATTERN_EN
        e_pat_r = 8'h00; e_pat_g = 8'h00; e_pat_b = 8'h00;
`endif
        while (cyc < 1202) tick();
        check("pat600_r", r, e_pat_r);
        check("pat600_g", g, e_pat_g);
        check("pat600_b", b, e_pat_b);
        check("pat600_blank", blank_n, 1'b1);
        test_pattern = 1'b0;

        // Asynchronous reset mid-frame at (300,2) while vga_clk is high
        r_in = 8'hAB; g_in = 8'hCD; b_in = 8'hEF;
        do_reset();
        while (cyc < 3801) tick();
        check("pre_rst_x", x, 10'd300);
        check("pre_rst_y", y, 10'd2);
        check("pre_rst_blank", blank_n, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_x", x, 10'd0);
        check("rst_y", y, 10'd0);
        check("rst_vgaclk", vga_clk, 1'b0);
        check("rst_hsync", hsync_n, 1'b1);
        check("rst_vsync", vsync_n, 1'b1);
        check("rst_blank", blank_n, 1'b0);
        check("rst_rgb", {r, g, b}, 24'h0);
        check("rst_vblank", vblank, 1'b0);
        check("rst_fstart", frame_start, 1'b0);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        tick();
        check("restart_x1", x, 10'd0);
        tick();
        check("restart_x2", x, 10'd1);
        check("restart_y2", y, 10'd0);
        check("restart_blank", blank_n, 1'b1);

        // Two-frame sweep: colour follows x/y like the renderer would
        err_xy = 0; err_clk = 0; err_sync = 0; err_blank = 0; err_rgb = 0; err_vb = 0; err_fs = 0;
        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1;
        r_in = 8'h00; g_in = 8'h5A; b_in = 8'hFF;
        do_reset();
        for (int k = 0; k < 2 * FRAME + 2; k++) begin
            tick();
            n    = cyc;
            ex_x = (n / 2) % 800;
            ex_y = (n / 1600) % VT;
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
            e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
            if (n >= 2) begin
                p  = n / 2 - 1;
                px = p % 800;
                py = (p / 800) % VT;
                e_hs = !(px >= 656 && px <= 751);
                e_vs = !(py >= 5 && py <= 6);
                e_bl = (px < 640) && (py < 4);
                if (e_bl) begin
                    e_r = 8'(px);
                    e_g = 8'(py) ^ 8'h5A;
                    e_b = ~8'(px);
                end
            end
            e_vb = (ex_y >= 4);
            e_fs = (n % FRAME == 0);
            if (x !== 10'(ex_x) || y !== 10'(ex_y)) err_xy++;
            if (vga_clk !== 1'(n % 2)) err_clk++;
            if (hsync_n !== e_hs || vsync_n !== e_vs) err_sync++;
            if (blank_n !== e_bl) err_blank++;
            if ({r, g, b} !== {e_r, e_g, e_b}) err_rgb++;
            if (vblank !== e_vb) err_vb++;
            if (frame_start !== e_fs) err_fs++;
            if (n % 2 == 0 && n >= 1602 && n <= 3200 && hsync_n == 1'b0) hs_low++;
            if (n % 2 == 0 && n >= 2 && n <= FRAME && vsync_n == 1'b0) vs_low++;
            if (n <= FRAME + 1600 && frame_start == 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
            end
            r_in = 8'(ex_x);
            g_in = 8'(ex_y) ^ 8'h5A;
            b_in = ~8'(ex_x);
        end
        check("sweep_xy_errors",    err_xy,    0);
        check("sweep_vgaclk_errors", err_clk,  0);
        check("sweep_sync_errors",  err_sync,  0);
        check("sweep_blank_errors", err_blank, 0);
        check("sweep_rgb_errors",   err_rgb,   0);
        check("sweep_vblank_errors", err_vb,   0);
        check("sweep_fstart_errors", err_fs,   0);
        check("hsync_low_pixels",   hs_low,    96);
        check("vsync_low_pixels",   vs_low,    1600);
        check("fstart_count",       fs_cnt,    1);
        check("fstart_first_cyc",   fs_first,  FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
